bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Parametrised sequential binary-to-BCD converter: successor to the fixed 5-bit combinational decoder.
//  Converts a WIDTH-bit unsigned value to DIGITS packed BCD digits with the shift-add-3 (double-dabble) algorithm.
//  Takes one bit per clock, using a start/busy/done handshake.
//  Feeds the display/multiplexing blocks downstream.
// PARAMETERS
//  WIDTH   8  binary input width, >=1
//  DIGITS  3  BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH-1 (checked at elaboration, $error if violated)
// PORTS
//  clk    in   1         rising-edge clock, single clock domain
//  rst    in   1         synchronous, active-high reset
//  start  in   1         request a conversion of bin; sampled on clk
//  bin    in   WIDTH     unsigned binary operand; captured when start is accepted
//  busy   out  1         high while a conversion is in progress
//  done   out  1         one-cycle pulse: bcd holds a new result
//  bcd    out  4*DIGITS  packed result; digit k = bcd[4k+3:4k], digit 0 = units
//  blank  out  DIGITS    leading-zero mask (only with BIN2BCD_BLANK_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, bcd=0, blank=0; scratch and counter cleared.
//    Reset mid-conversion aborts the conversion; no done pulse follows.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE  -> SHIFT  on start: latch bin, clear BCD scratch, cnt=WIDTH.
//    SHIFT -> SHIFT  while cnt>1. Each cycle:
//      * every scratch digit >=5 gets +3 (combinational);
//      * then {scratch,bin_sr} shifts left 1;
//      * cnt decrements.
//    SHIFT -> DONE   on the last shift (cnt==1): result written to the bcd register.
//    DONE  -> IDLE   if !start. DONE -> SHIFT on start (back-to-back accept, new bin latched).
//  - busy = (state==SHIFT). done = (state==DONE), one cycle exactly.
//  - Latency: start sampled at edge t -> done high during cycle t+WIDTH+1.
//    Max throughput is one result per WIDTH+1 cycles.
//  - start while busy is ignored: no restart, no queueing, operand unchanged.
//  - bcd is stable between done pulses; it updates only on entry to DONE.
//  - Arithmetic:
//    * add-3 is 4-bit and cannot overflow for a digit in 0..9 pre-shift;
//    * the scratch is 4*DIGITS bits;
//    * bits shifted out of the top digit are discarded. This is legal only because the DIGITS constraint holds.
//  - Boundaries:
//    * bin=0 -> all digits 0;
//    * bin=2**WIDTH-1 -> exact decimal;
//    * WIDTH=1 -> single SHIFT cycle.
// CONFIGURATION
//  - BIN2BCD_BLANK_EN defined:
//    * blank[k]=1 when digit k and all higher digits are 0, for k>=1;
//    * blank[0] is always 0;
//    * registered with bcd; reset 0.
//  - Not defined: the blank port is absent; no blanking logic is built.
// STRUCTURE
//  - Shared header bin2bcd_defs.vh:
//    * state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
//    * a clog2 helper function for the counter width;
//    * a digits_needed(WIDTH) function for the elaboration check.
//  - Sub-module bcd_add3: combinational 4-bit cell, out = (in>=5) ? in+3 : in.
//    Instantiated DIGITS times in a generate loop.
//  - Counter width clog2(WIDTH+1).
// TESTING
//  Bench uses WIDTH=8, DIGITS=3 unless noted.
//  1. Exhaustive: bin=0..255, one start each, wait done.
//     -> bcd equals decimal of bin for every value; done exactly 9 cycles after start.
//  2. bin=8'd255 -> bcd=12'h255, busy high 8 cycles, done 1 cycle.
//     bin=8'd0 -> bcd=12'h000.
//  3. Start bin=8'd123; re-assert start with bin=8'd45 on cycle 3.
//     -> ignored; done once with bcd=12'h123.
//  4. Start bin=8'd200; rst on cycle 4.
//     -> all outputs 0 next cycle, no done.
//     New start with bin=8'd9 -> bcd=12'h009.
//  5. start held high continuously, bin stepping 10,20,30.
//     -> done every 9 cycles, bcd = 12'h010, 12'h020, 12'h030.
//  6. WIDTH=5, DIGITS=2, bin=0..31 -> matches the legacy decoder: bin=31 -> bcd=8'h31.
//     With BIN2BCD_BLANK_EN, WIDTH=8: bin=7 -> blank=3'b110; bin=0 -> blank=3'b110; bin=100 -> blank=3'b000.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared definitions for the sequential binary-to-BCD converter.
//   - state_t     : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   - clog2       : ceiling log2, sizes the bit counter
//   - digits_needed : decimal digits needed for the largest WIDTH-bit value
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Number of decimal digits in 2**width-1 (at least one).
  function automatic int digits_needed(input int width);
    logic [63:0] max_v;
    int          d;
    max_v = (64'd1 << width) - 64'd1;
    d     = 32'sd1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      d     = d + 32'sd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3: combinational double-dabble correction cell.
//   din  [3:0] : BCD digit before the shift
//   dout [3:0] : din+3 when din>=5, otherwise din unchanged
// Digits entering this cell are always 0..9, so the 4-bit add never wraps.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential WIDTH-bit binary to DIGITS-digit packed BCD converter
// (shift-add-3, one input bit per clock).
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, aborts any conversion in flight
//   start : conversion request, accepted in IDLE or DONE
//   bin   : operand, captured when start is accepted
//   busy  : high while shifting
//   done  : one-cycle pulse, bcd holds a new result
//   bcd   : packed result, digit k = bcd[4k+3:4k], digit 0 = units
//   blank : leading-zero mask, present only when BIN2BCD_BLANK_EN is defined
// Optional feature macro: BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(32'd1);

  // Discarding bits shifted out of the top digit is only safe when the
  // scratch can represent the largest operand.
  if (DIGITS < digits_needed(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t              state_r;
  logic [WIDTH-1:0]    bin_sr_r;
  logic [SW-1:0]       scratch_r;
  logic [CW-1:0]       cnt_r;
  logic [SW-1:0]       bcd_r;
  logic                busy_r;
  logic                done_r;
  logic [SW-1:0]       adj_s;
  logic [SW-1:0]       shifted_s;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_r[4*k +: 4]),
      .dout (adj_s[4*k +: 4])
    );
  end

  // Corrected scratch shifted left with the next operand bit entering at the bottom.
  assign shifted_s = {adj_s[SW-2:0], bin_sr_r[WIDTH-1]};

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bin_sr_r  <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      bcd_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r   <= SHIFT;
            busy_r    <= 1'b1;
            bin_sr_r  <= bin;
            scratch_r <= '0;
            cnt_r     <= CNT_INIT;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          scratch_r <= shifted_s;
          bin_sr_r  <= bin_sr_r << 1;
          cnt_r     <= cnt_r - CNT_LAST;
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            bcd_r   <= shifted_s;
          end else begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_s;
  logic [DIGITS-1:0] blank_r;
  logic              zero_above_s;

  // Digit k is blanked when it and every digit above it are zero; units never blank.
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above_s = zero_above_s & (shifted_s[4*k +: 4] == 4'd0);
      blank_s[k]   = zero_above_s;
    end
  end

  // Blank mask is captured together with the result on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_r <= '0;
    end else if ((state_r == SHIFT) && (cnt_r == CNT_LAST)) begin
      blank_r <= blank_s;
    end else begin
      blank_r <= blank_r;
    end
  end

  assign blank = blank_r;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed self-checking bench for bin2bcd_seq.
// Main instance WIDTH=8/DIGITS=3, second instance WIDTH=5/DIGITS=2.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic        busy, done;
  logic [11:0] bcd;
  logic        start5 = 1'b0;
  logic [4:0]  bin5 = 5'd0;
  logic        busy5, done5;
  logic [7:0]  bcd5;
`ifdef BIN2BCD_BLANK_EN
  logic [2:0]  blank;
  logic [1:0]  blank5;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank)
`endif
  );

  bin2bcd_seq #(.WIDTH(5), .DIGITS(2)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .bin(bin5),
    .busy(busy5), .done(done5), .bcd(bcd5)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank5)
`endif
  );

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] dec2(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One conversion on the 8-bit instance; lat = edges after the accepting edge
  // until done is seen (-1 on timeout).
  task automatic convert8(input logic [7:0] b, output logic [11:0] res, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    res   = bcd;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        res = bcd;
        break;
      end
    end
  endtask

  task automatic convert5(input logic [4:0] b, output logic [7:0] res, output int lat);
    @(negedge clk);
    start5 = 1'b1;
    bin5   = b;
    @(posedge clk);
    @(negedge clk);
    start5 = 1'b0;
    lat    = -1;
    res    = bcd5;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done5 === 1'b1) begin
        lat = i;
        res = bcd5;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bcd} !== 14'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b bcd=%h exp 0 0 000", busy, done, bcd);
    end
    checks++;
    if ({busy5, done5, bcd5} !== 10'd0) begin
      errors++;
      $display("FAIL reset5 got busy=%b done=%b bcd=%h exp 0 0 00", busy5, done5, bcd5);
    end
`ifdef BIN2BCD_BLANK_EN
    checks++;
    if ({blank, blank5} !== 5'd0) begin
      errors++;
      $display("FAIL reset_blank got %b/%b exp 000/00", blank, blank5);
    end
`endif
    rst = 1'b0;
  endtask

  // Every 8-bit operand; done must come WIDTH edges after the accepting edge,
  // i.e. in the 9th cycle counting the start cycle.
  task automatic test_exhaustive();
    logic [11:0] res;
    int          lat;
    for (int v = 0; v < 256; v++) begin
      convert8(8'(v), res, lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL exhaustive_latency bin=%0d got=%0d exp=8", v, lat);
      end
      checks++;
      if (res !== dec3(v)) begin
        errors++;
        $display("FAIL exhaustive_bcd bin=%0d got=%h exp=%h", v, res, dec3(v));
      end
    end
  endtask

  task automatic test_extremes();
    logic [11:0] res;
    int          lat;
    int          busy_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd255;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    lat      = -1;
    for (int i = 0; i <= 20; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (busy_cnt !== 8 || lat !== 8) begin
      errors++;
      $display("FAIL max_busy got busy_cycles=%0d latency=%0d exp 8 8", busy_cnt, lat);
    end
    checks++;
    if (bcd !== 12'h255) begin
      errors++;
      $display("FAIL max_bcd got=%h exp=255", bcd);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bcd !== 12'h255) begin
      errors++;
      $display("FAIL done_pulse got done=%b bcd=%h exp 0 255", done, bcd);
    end
    convert8(8'd0, res, lat);
    checks++;
    if (res !== 12'h000 || lat !== 8) begin
      errors++;
      $display("FAIL zero_bcd got=%h lat=%0d exp 000 8", res, lat);
    end
  endtask

  task automatic test_ignore_start();
    int          ndone;
    int          lat;
    logic [11:0] res;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd123;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = 8'd0;
    ndone = 0;
    lat   = -1;
    res   = 12'h000;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        if (ndone == 0) begin
          lat = i;
          res = bcd;
        end
        ndone++;
      end
      if (i == 2) begin
        start = 1'b1;
        bin   = 8'd45;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (ndone !== 1 || lat !== 8) begin
      errors++;
      $display("FAIL ignore_start got dones=%0d latency=%0d exp 1 8", ndone, lat);
    end
    checks++;
    if (res !== 12'h123) begin
      errors++;
      $display("FAIL ignore_start_bcd got=%h exp=123", res);
    end
  endtask

  task automatic test_reset_abort();
    int          ndone;
    int          lat;
    logic [11:0] res;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got=%b exp=1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, bcd} !== 14'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b done=%b bcd=%h exp 0 0 000", busy, done, bcd);
    end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_no_done got dones=%0d exp=0", ndone);
    end
    convert8(8'd9, res, lat);
    checks++;
    if (res !== 12'h009 || lat !== 8) begin
      errors++;
      $display("FAIL after_abort got=%h lat=%0d exp 009 8", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    int          k;
    int          idx [3];
    logic [11:0] val [3];
    logic [11:0] exp_val [3];
    exp_val[0] = 12'h010;
    exp_val[1] = 12'h020;
    exp_val[2] = 12'h030;
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd10;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        idx[k] = i;
        val[k] = bcd;
        k++;
        if (k < 3) bin = 8'((k + 1) * 10);
        else start = 1'b0;
      end
      if (k == 3) break;
    end
    start = 1'b0;
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL b2b_count got dones=%0d exp=3", k);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (idx[j] !== 8 + 9 * j || val[j] !== exp_val[j]) begin
          errors++;
          $display("FAIL b2b_result%0d got cycle=%0d bcd=%h exp cycle=%0d bcd=%h",
                   j, idx[j], val[j], 8 + 9 * j, exp_val[j]);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_width5();
    logic [7:0] res;
    int         lat;
    for (int v = 0; v < 32; v++) begin
      convert5(5'(v), res, lat);
      checks++;
      if (res !== dec2(v) || lat !== 5) begin
        errors++;
        $display("FAIL width5 bin=%0d got=%h lat=%0d exp=%h 5", v, res, lat, dec2(v));
      end
    end
    checks++;
    if (bcd5 !== 8'h31) begin
      errors++;
      $display("FAIL width5_max got=%h exp=31", bcd5);
    end
  endtask

`ifdef BIN2BCD_BLANK_EN
  task automatic test_blank();
    logic [11:0] res;
    int          lat;
    logic [7:0]  vin [3];
    logic [2:0]  vexp [3];
    vin[0] = 8'd7;   vexp[0] = 3'b110;
    vin[1] = 8'd0;   vexp[1] = 3'b110;
    vin[2] = 8'd100; vexp[2] = 3'b000;
    for (int j = 0; j < 3; j++) begin
      convert8(vin[j], res, lat);
      checks++;
      if (blank !== vexp[j] || lat !== 8) begin
        errors++;
        $display("FAIL blank bin=%0d got=%b exp=%b", vin[j], blank, vexp[j]);
      end
    end
    convert8(8'd42, res, lat);
    checks++;
    if (blank !== 3'b100) begin
      errors++;
      $display("FAIL blank bin=42 got=%b exp=100", blank);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive();
    test_extremes();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_width5();
`ifdef BIN2BCD_BLANK_EN
    test_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
